tlb_nway: RTL and testbench
===========================

TLB_NWAY -- requirements
Module: tlb_nway

Interface
REQ-001 SHALL have parameter VA_W, default 32, virtual address width.
REQ-002 SHALL have parameter PA_W, default 32, physical address width.
REQ-003 SHALL have parameter OFF_W, default 12, page offset width.
REQ-004 SHALL have parameter SETS, default 64, set count (power of 2, >=2).
REQ-005 SHALL have parameter WAYS, default 4, associativity (power of 2, >=2).
REQ-006 SHALL have parameter ASID_W, default 8, address-space ID width.
REQ-007 SHALL have ports as listed; reset reset, synchronous, active-high; clock clk:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 req_valid  in  1  lookup request
 req_ready  out  1  lookup accepted when high with req_valid
 req_vaddr  in  VA_W  lookup address
 req_asid  in  ASID_W  lookup ASID
 rsp_valid  out  1  lookup result valid (one-cycle pulse)
 rsp_hit  out  1  translation found
 rsp_paddr  out  PA_W  {ppage, offset} on hit, 0 on miss
 upd_valid  in  1  fill/update request
 upd_ready  out  1  update accepted when high with upd_valid
 upd_vaddr  in  VA_W  update virtual address
 upd_paddr  in  PA_W  update physical address
 upd_asid  in  ASID_W  update ASID
 upd_global  in  1  entry matches any ASID
 flush_req  in  1  invalidate all entries
 flush_busy  out  1  invalidation walk in progress

Function
REQ-008 SHALL derive index = vaddr[OFF_W +: log2(SETS)], tag = remaining upper VA bits, ppage = paddr[PA_W-1:OFF_W].
REQ-009 SHALL register lookup: accepted request in cycle N -> rsp_valid/rsp_hit/rsp_paddr in cycle N+1; no response backpressure.
REQ-010 SHALL hit when an entry in the set is valid and its tag matches; on multiple hits lowest way index wins.
REQ-011 SHALL apply an accepted update at the clock edge: matching valid entry -> overwrite ppage (and ASID/global); else lowest-index invalid way; else way at per-set round-robin pointer.
REQ-012 SHALL advance the set's round-robin pointer (mod WAYS) only on replacement of a valid entry.
REQ-013 SHALL, for simultaneous lookup and update to the same set, return pre-update contents to the lookup.
REQ-014 SHALL implement FSM states IDLE and WALK; flush_req in IDLE -> WALK; WALK clears one set's valid bits and pointer per cycle, indices 0..SETS-1, then returns to IDLE (SETS cycles total).
REQ-015 SHALL hold req_ready, upd_ready low and flush_busy high while in WALK; high/high/low in IDLE.
REQ-016 SHALL ignore flush_req while in WALK; a lookup accepted the cycle before WALK entry still completes.

Reset
REQ-017 SHALL on reset enter WALK at set 0, clearing rsp_valid, rsp_hit, rsp_paddr to 0; req_ready=0, upd_ready=0, flush_busy=1 until the walk ends.
REQ-018 SHALL restart the walk at set 0 when reset asserts mid-walk.

Configuration
REQ-019 SHALL, with TLB_ASID_EN defined, store ASID and global bit per entry and additionally require (global or stored ASID == req_asid) for a hit and for the REQ-011 in-place match.
REQ-020 SHALL, without TLB_ASID_EN, store no ASID/global state and ignore req_asid, upd_asid, upd_global.

Structure
REQ-021 SHALL place default parameters, the entry struct typedef and the FSM state enum in package tlb_pkg.
REQ-022 SHALL use sub-module tlb_set_match (combinational per-set compare returning hit, hit way, first invalid way).

Verification
REQ-023 SHALL cover: after reset, flush_busy high exactly 64 cycles, then lookup 0x0000_5123 -> rsp_hit=0, rsp_paddr=0.
REQ-024 SHALL cover: update 0x0004_7000->0x1234_5000, then lookup 0x0004_7ABC -> next cycle rsp_hit=1, rsp_paddr=0x1234_5ABC.
REQ-025 SHALL cover: five updates, same index, distinct tags -> fifth replaces way 0; second set of five replaces way 1.
REQ-026 SHALL cover: lookup and update to same vaddr same cycle -> miss; repeat lookup -> hit.
REQ-027 SHALL cover (TLB_ASID_EN): entry ASID 3 non-global; lookup ASID 4 -> miss; global entry -> hit for ASID 4.
REQ-028 SHALL cover: flush_req after fills -> all lookups miss; reset at walk cycle 10 -> walk restarts, 64 cycles busy.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared defaults, FSM encoding and entry layout for the set-associative TLB.
// Entry fields are sized for the widest supported configuration; unused upper bits stay zero.
package tlb_pkg;

    localparam int TLB_VA_W   = 32;
    localparam int TLB_PA_W   = 32;
    localparam int TLB_OFF_W  = 12;
    localparam int TLB_SETS   = 64;
    localparam int TLB_WAYS   = 4;
    localparam int TLB_ASID_W = 8;

    localparam int TLB_TAG_MAX_W  = 64;
    localparam int TLB_PPN_MAX_W  = 64;
    localparam int TLB_ASID_MAX_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } tlb_state_e;

    typedef struct packed {
        logic [TLB_TAG_MAX_W-1:0]  tag;
        logic [TLB_PPN_MAX_W-1:0]  ppn;
`ifdef TLB_ASID_EN
        logic                      glb;
        logic [TLB_ASID_MAX_W-1:0] asid;
`endif
    } tlb_entry_t;

endpackage

// File: rtl/tlb_set_match.sv
// Combinational compare of one set: first matching way, and first invalid way (lowest index wins).
module tlb_set_match #(
    parameter int WAYS   = 4,
`ifdef TLB_ASID_EN
    parameter int ASID_W = 16,
`endif
    parameter int TAG_W  = 64
) (
    input  logic [WAYS-1:0]              valid_i,
    input  logic [WAYS-1:0][TAG_W-1:0]   tags_i,
    input  logic [TAG_W-1:0]             tag_i,
`ifdef TLB_ASID_EN
    input  logic [WAYS-1:0]              glb_i,
    input  logic [WAYS-1:0][ASID_W-1:0]  asids_i,
    input  logic [ASID_W-1:0]            asid_i,
`endif
    output logic                         hit_o,
    output logic [$clog2(WAYS)-1:0]      hit_way_o,
    output logic                         inv_o,
    output logic [$clog2(WAYS)-1:0]      inv_way_o
);

    logic [WAYS-1:0] match;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
`ifdef TLB_ASID_EN
            match[w] = valid_i[w] && (tags_i[w] == tag_i) && (glb_i[w] || (asids_i[w] == asid_i));
`else
            match[w] = valid_i[w] && (tags_i[w] == tag_i);
`endif
        end
    end

    // Scan high to low so the lowest matching index is the last assignment.
    always_comb begin
        hit_o     = 1'b0;
        hit_way_o = '0;
        inv_o     = 1'b0;
        inv_way_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_o     = 1'b1;
                hit_way_o = ($clog2(WAYS))'(w);
            end
            if (!valid_i[w]) begin
                inv_o     = 1'b1;
                inv_way_o = ($clog2(WAYS))'(w);
            end
        end
    end

endmodule

// File: rtl/tlb_nway.sv
// N-way TLB: one-cycle registered lookup, in-place/invalid/round-robin fill, SETS-cycle flush walk.
// Requests and updates stall (ready low) only during the walk; optional ASID tagging under TLB_ASID_EN.
module tlb_nway
    import tlb_pkg::*;
#(
    parameter int VA_W   = TLB_VA_W,
    parameter int PA_W   = TLB_PA_W,
    parameter int OFF_W  = TLB_OFF_W,
    parameter int SETS   = TLB_SETS,
    parameter int WAYS   = TLB_WAYS,
    parameter int ASID_W = TLB_ASID_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VA_W-1:0]   req_vaddr,
    input  logic [ASID_W-1:0] req_asid,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [PA_W-1:0]   rsp_paddr,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [VA_W-1:0]   upd_vaddr,
    input  logic [PA_W-1:0]   upd_paddr,
    input  logic [ASID_W-1:0] upd_asid,
    input  logic              upd_global,
    input  logic              flush_req,
    output logic              flush_busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = VA_W - OFF_W - IDX_W;

    tlb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  walk_q, walk_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [PA_W-1:0]   rsp_paddr_q, rsp_paddr_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    tlb_entry_t        ent_q   [SETS][WAYS];

    logic              idle, req_fire, upd_fire;
    logic [IDX_W-1:0]  req_idx, upd_idx;
    logic [TAG_W-1:0]  req_tag, upd_tag;

    assign idle       = (state_q == ST_IDLE);
    assign req_ready  = idle;
    assign upd_ready  = idle;
    assign flush_busy = !idle;
    assign req_fire   = req_valid && idle;
    assign upd_fire   = upd_valid && idle;

    assign req_idx = req_vaddr[OFF_W +: IDX_W];
    assign upd_idx = upd_vaddr[OFF_W +: IDX_W];
    assign req_tag = req_vaddr[VA_W-1 -: TAG_W];
    assign upd_tag = upd_vaddr[VA_W-1 -: TAG_W];

    logic [WAYS-1:0][TLB_TAG_MAX_W-1:0] rd_tags, up_tags;
    logic              rd_hit, up_hit, up_inv, rd_inv_unused;
    logic [WAY_W-1:0]  rd_hit_way, up_hit_way, up_inv_way, rd_inv_way_unused, upd_way;
    tlb_entry_t        upd_ent;

`ifdef TLB_ASID_EN
    logic [WAYS-1:0][TLB_ASID_MAX_W-1:0] rd_asids, up_asids;
    logic [WAYS-1:0]                     rd_glb, up_glb;
`else
    logic unused_bits;
    assign unused_bits = ^{req_asid, upd_asid, upd_global};
`endif
    logic unused_off;
    assign unused_off = ^{upd_vaddr[OFF_W-1:0], upd_paddr[OFF_W-1:0]};

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            rd_tags[w] = ent_q[req_idx][w].tag;
            up_tags[w] = ent_q[upd_idx][w].tag;
`ifdef TLB_ASID_EN
            rd_asids[w] = ent_q[req_idx][w].asid;
            up_asids[w] = ent_q[upd_idx][w].asid;
            rd_glb[w]   = ent_q[req_idx][w].glb;
            up_glb[w]   = ent_q[upd_idx][w].glb;
`endif
        end
    end

    tlb_set_match #(
        .WAYS   (WAYS),
`ifdef TLB_ASID_EN
        .ASID_W (TLB_ASID_MAX_W),
`endif
        .TAG_W  (TLB_TAG_MAX_W)
    ) u_rd_match (
        .valid_i   (valid_q[req_idx]),
        .tags_i    (rd_tags),
        .tag_i     (TLB_TAG_MAX_W'(req_tag)),
`ifdef TLB_ASID_EN
        .glb_i     (rd_glb),
        .asids_i   (rd_asids),
        .asid_i    (TLB_ASID_MAX_W'(req_asid)),
`endif
        .hit_o     (rd_hit),
        .hit_way_o (rd_hit_way),
        .inv_o     (rd_inv_unused),
        .inv_way_o (rd_inv_way_unused)
    );

    tlb_set_match #(
        .WAYS   (WAYS),
`ifdef TLB_ASID_EN
        .ASID_W (TLB_ASID_MAX_W),
`endif
        .TAG_W  (TLB_TAG_MAX_W)
    ) u_up_match (
        .valid_i   (valid_q[upd_idx]),
        .tags_i    (up_tags),
        .tag_i     (TLB_TAG_MAX_W'(upd_tag)),
`ifdef TLB_ASID_EN
        .glb_i     (up_glb),
        .asids_i   (up_asids),
        .asid_i    (TLB_ASID_MAX_W'(upd_asid)),
`endif
        .hit_o     (up_hit),
        .hit_way_o (up_hit_way),
        .inv_o     (up_inv),
        .inv_way_o (up_inv_way)
    );

    // Victim choice: in-place match, then first free way, then round-robin.
    assign upd_way = up_hit ? up_hit_way : (up_inv ? up_inv_way : rr_q[upd_idx]);

    always_comb begin
        upd_ent      = '0;
        upd_ent.tag  = TLB_TAG_MAX_W'(upd_tag);
        upd_ent.ppn  = TLB_PPN_MAX_W'(upd_paddr[PA_W-1:OFF_W]);
`ifdef TLB_ASID_EN
        upd_ent.glb  = upd_global;
        upd_ent.asid = TLB_ASID_MAX_W'(upd_asid);
`endif
    end

    always_comb begin
        rsp_valid_d = req_fire;
        rsp_hit_d   = req_fire && rd_hit;
        rsp_paddr_d = '0;
        if (req_fire && rd_hit)
            rsp_paddr_d = PA_W'({ent_q[req_idx][rd_hit_way].ppn, req_vaddr[OFF_W-1:0]});
    end

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_WALK;
                    walk_d  = '0;
                end
            end
            default: begin
                walk_d = walk_q + IDX_W'(1);
                if (walk_q == IDX_W'(SETS - 1))
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WALK;
            walk_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_paddr_q <= '0;
        end else begin
            state_q     <= state_d;
            walk_q      <= walk_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_paddr_q <= rsp_paddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!idle) begin
                valid_q[walk_q] <= '0;
                rr_q[walk_q]    <= '0;
            end else if (upd_fire) begin
                valid_q[upd_idx][upd_way] <= 1'b1;
                if (!up_hit && !up_inv)
                    rr_q[upd_idx] <= rr_q[upd_idx] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_fire)
            ent_q[upd_idx][upd_way] <= upd_ent;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_paddr = rsp_paddr_q;

endmodule

// File: tb/tb_tlb_nway.sv
// Directed bench for tlb_nway: vector table for basic translate/fill, hand sequences for walk,
// replacement order, same-cycle hazard and reset-during-walk.
module tb_tlb_nway;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_vaddr;
    logic [7:0]  req_asid;
    logic        rsp_valid, rsp_hit;
    logic [31:0] rsp_paddr;
    logic        upd_valid, upd_ready;
    logic [31:0] upd_vaddr, upd_paddr;
    logic [7:0]  upd_asid;
    logic        upd_global;
    logic        flush_req, flush_busy;

    always #5 clk = ~clk;

    tlb_nway dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vaddr  (req_vaddr),
        .req_asid   (req_asid),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_paddr  (rsp_paddr),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_vaddr  (upd_vaddr),
        .upd_paddr  (upd_paddr),
        .upd_asid   (upd_asid),
        .upd_global (upd_global),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        bit          is_upd;
        logic [31:0] va;
        logic [31:0] pa;
        logic        hit;
        logic [31:0] exp_pa;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] va, input logic [7:0] asid,
                          input logic exp_hit, input logic [31:0] exp_pa, input string nm);
        req_valid = 1'b1;
        req_vaddr = va;
        req_asid  = asid;
        step();
        req_valid = 1'b0;
        chk({nm, ".vld"},   32'(rsp_valid), 32'd1);
        chk({nm, ".hit"},   32'(rsp_hit),   32'(exp_hit));
        chk({nm, ".paddr"}, rsp_paddr,      exp_pa);
    endtask

    task automatic update(input logic [31:0] va, input logic [31:0] pa,
                          input logic [7:0] asid, input logic glb);
        upd_valid  = 1'b1;
        upd_vaddr  = va;
        upd_paddr  = pa;
        upd_asid   = asid;
        upd_global = glb;
        step();
        upd_valid  = 1'b0;
    endtask

    task automatic count_busy(output int n, input int pulse_at);
        n = 0;
        while (flush_busy === 1'b1 && n < 200) begin
            if (n == pulse_at) flush_req = 1'b1;
            step();
            flush_req = 1'b0;
            n++;
        end
    endtask

    function automatic logic [31:0] rva(input int t);
        return (32'(t) << 18) | 32'h0000_5010;
    endfunction

    function automatic logic [31:0] rpa(input int t);
        return 32'h8000_0000 | (32'(t) << 12);
    endfunction

    initial begin
        int n;
        reset = 1'b1;
        req_valid = 1'b0; req_vaddr = '0; req_asid = '0;
        upd_valid = 1'b0; upd_vaddr = '0; upd_paddr = '0; upd_asid = '0; upd_global = 1'b0;
        flush_req = 1'b0;

        vecs[0]  = '{1'b1, 32'h0004_7000, 32'h1234_5000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0004_7ABC, 32'h0,         1'b1, 32'h1234_5ABC};
        vecs[2]  = '{1'b0, 32'h0000_7ABC, 32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0004_8ABC, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0004_7000, 32'h0BAD_F000, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0004_7001, 32'h0,         1'b1, 32'h0BAD_F001};
        vecs[6]  = '{1'b1, 32'h0000_8000, 32'hAAAA_A000, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_8FFF, 32'h0,         1'b1, 32'hAAAA_AFFF};
        vecs[8]  = '{1'b0, 32'h0004_7FFF, 32'h0,         1'b1, 32'h0BAD_FFFF};
        vecs[9]  = '{1'b1, 32'hFFFF_F000, 32'hFFFF_F000, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'hFFFF_F123, 32'h0,         1'b1, 32'hFFFF_F123};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};

        // reset state and initial walk length
        repeat (3) step();
        chk("rst.rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst.rsp_hit",    32'(rsp_hit),    32'd0);
        chk("rst.rsp_paddr",  rsp_paddr,       32'd0);
        chk("rst.req_ready",  32'(req_ready),  32'd0);
        chk("rst.upd_ready",  32'(upd_ready),  32'd0);
        chk("rst.flush_busy", 32'(flush_busy), 32'd1);
        reset = 1'b0;
        count_busy(n, -1);
        chk("rst.walk_len",   32'(n),          32'd64);
        chk("idle.req_ready", 32'(req_ready),  32'd1);
        chk("idle.upd_ready", 32'(upd_ready),  32'd1);
        lookup(32'h0000_5123, 8'd0, 1'b0, 32'h0, "cold_miss");

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_upd) update(vecs[i].va, vecs[i].pa, 8'd0, 1'b0);
            else lookup(vecs[i].va, 8'd0, vecs[i].hit, vecs[i].exp_pa, $sformatf("vec%0d", i));
        end

        // round-robin replacement within set 5
        for (int t = 1; t <= 5; t++) update(rva(t), rpa(t), 8'd0, 1'b0);
        lookup(rva(1), 8'd0, 1'b0, 32'h0,                 "rr1.t1");
        lookup(rva(2), 8'd0, 1'b1, rpa(2) | 32'h010,      "rr1.t2");
        lookup(rva(5), 8'd0, 1'b1, rpa(5) | 32'h010,      "rr1.t5");
        for (int t = 6; t <= 10; t++) update(rva(t), rpa(t), 8'd0, 1'b0);
        lookup(rva(5),  8'd0, 1'b0, 32'h0,                "rr2.t5");
        lookup(rva(6),  8'd0, 1'b0, 32'h0,                "rr2.t6");
        lookup(rva(7),  8'd0, 1'b1, rpa(7)  | 32'h010,    "rr2.t7");
        lookup(rva(10), 8'd0, 1'b1, rpa(10) | 32'h010,    "rr2.t10");

        // same-cycle lookup and update sees old contents
        req_valid = 1'b1; req_vaddr = 32'h0123_4567; req_asid = '0;
        upd_valid = 1'b1; upd_vaddr = 32'h0123_4000; upd_paddr = 32'h0055_5000;
        upd_asid = '0; upd_global = 1'b0;
        step();
        req_valid = 1'b0; upd_valid = 1'b0;
        chk("hazard.vld",   32'(rsp_valid), 32'd1);
        chk("hazard.hit",   32'(rsp_hit),   32'd0);
        chk("hazard.paddr", rsp_paddr,      32'd0);
        lookup(32'h0123_4567, 8'd0, 1'b1, 32'h0055_5567, "hazard.again");

        // flush: lookup issued with flush_req completes, then the walk stalls everything
        flush_req = 1'b1; req_valid = 1'b1; req_vaddr = 32'h0004_7ABC;
        step();
        flush_req = 1'b0; req_valid = 1'b0;
        chk("flush.last_vld",   32'(rsp_valid),  32'd1);
        chk("flush.last_paddr", rsp_paddr,       32'h0BAD_FABC);
        chk("flush.busy",       32'(flush_busy), 32'd1);
        req_valid = 1'b1; upd_valid = 1'b1; upd_vaddr = 32'h0;
        step();
        req_valid = 1'b0; upd_valid = 1'b0;
        chk("walk.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("walk.req_ready", 32'(req_ready), 32'd0);
        chk("walk.upd_ready", 32'(upd_ready), 32'd0);
        count_busy(n, 20);
        chk("flush.walk_len", 32'(n + 1), 32'd64);
        lookup(32'h0004_7ABC, 8'd0, 1'b0, 32'h0, "postflush.a");
        lookup(32'h0000_8FFF, 8'd0, 1'b0, 32'h0, "postflush.b");
        lookup(32'hFFFF_F123, 8'd0, 1'b0, 32'h0, "postflush.c");
        lookup(rva(7),        8'd0, 1'b0, 32'h0, "postflush.d");

        // reset at walk cycle 10 restarts the full walk
        update(32'h0004_7000, 32'h1234_5000, 8'd0, 1'b0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst.busy", 32'(flush_busy), 32'd1);
        count_busy(n, -1);
        chk("midrst.walk_len", 32'(n), 32'd64);
        lookup(32'h0004_7ABC, 8'd0, 1'b0, 32'h0, "midrst.miss");

`ifdef TLB_ASID_EN
        update(32'h0010_0000, 32'h0000_3000, 8'd3, 1'b0);
        lookup(32'h0010_0010, 8'd4, 1'b0, 32'h0,         "asid.other");
        lookup(32'h0010_0010, 8'd3, 1'b1, 32'h0000_3010, "asid.own");
        update(32'h0020_0000, 32'h0000_4000, 8'd3, 1'b1);
        lookup(32'h0020_0020, 8'd4, 1'b1, 32'h0000_4020, "asid.global");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
